// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI burst controller.
package spi_pkg;

    localparam int SPI_WIDTH = 9;
    localparam int GAP_DEF   = 4;
    localparam int TMO_DEF   = 4096;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LO,
        WAIT_HI,
        CAPT,
        GAP_W
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    // A write into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    assign head  = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Queues words for the SPI master, sequences one frame per word with start strobes,
// and captures each received word into an RX FIFO.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter int DEPTH = 8,
    parameter int GAP   = GAP_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             go,
    output logic             tx_full,
    output logic             st,
    output logic [WIDTH-1:0] DI,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DO,
    input  logic             rx_rd,
    output logic [WIDTH-1:0] rx_dat,
    output logic             rx_empty,
    output logic [WIDTH-1:0] last_rx,
    output logic             busy,
    output logic             ovf,
    output logic             err
);
    localparam int CW = $clog2(TMO + GAP + 1);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             st_reg;
    logic [WIDTH-1:0] di_reg;
    logic [WIDTH-1:0] last_rx_reg;
    logic             ovf_reg;
    logic             err_reg;
    logic             load_s1_reg;
    logic             load_s2_reg;
    logic             load_d_reg;

    logic             tx_empty;
    logic [WIDTH-1:0] tx_head;
    logic             tx_pop;
    logic             rx_push;
    logic             rx_full;
    logic             load_rise;
    logic             tx_drop;
    logic             rx_drop;

    assign tx_pop    = (state_reg == START);
    assign rx_push   = (state_reg == CAPT);
    assign load_rise = load_s2_reg && !load_d_reg;
    assign tx_drop   = wr_en && tx_full && !tx_pop;
    assign rx_drop   = rx_push && rx_full && !rx_rd;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk    (clk),
        .clr    (clr),
        .wr_en  (wr_en),
        .wr_dat (wr_dat),
        .rd_en  (tx_pop),
        .full   (tx_full),
        .empty  (tx_empty),
        .head   (tx_head)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk    (clk),
        .clr    (clr),
        .wr_en  (rx_push),
        .wr_dat (DO),
        .rd_en  (rx_rd),
        .full   (rx_full),
        .empty  (rx_empty),
        .head   (rx_dat)
    );

    // LOAD idles high, so the synchronizer resets high to avoid a false edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            load_s1_reg <= 1'b1;
            load_s2_reg <= 1'b1;
            load_d_reg  <= 1'b1;
        end else begin
            load_s1_reg <= LOAD;
            load_s2_reg <= load_s1_reg;
            load_d_reg  <= load_s2_reg;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            st_reg      <= 1'b0;
            di_reg      <= '0;
            last_rx_reg <= '0;
            ovf_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            st_reg <= 1'b0;
            if (tx_drop || rx_drop) ovf_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (go && !tx_empty) state_reg <= START;
                end
                START: begin
                    di_reg    <= tx_head;
                    st_reg    <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!load_s2_reg) begin
                        cnt_reg   <= '0;
                        state_reg <= WAIT_HI;
                    end else if (cnt_reg == CW'(TMO - 1)) begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (load_rise) begin
                        state_reg <= CAPT;
                    end else if (cnt_reg == CW'(TMO - 1)) begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                CAPT: begin
                    last_rx_reg <= DO;
                    cnt_reg     <= '0;
                    state_reg   <= GAP_W;
                end
                GAP_W: begin
                    if (cnt_reg == CW'(GAP - 1)) begin
                        state_reg <= tx_empty ? IDLE : START;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign st      = st_reg;
    assign DI      = di_reg;
    assign last_rx = last_rx_reg;
    assign busy    = (state_reg != IDLE);
    assign ovf     = ovf_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Randomized bench for spi_burst_ctrl with a loop-back master (DO = ~DI) and queue-based model.
module tb_spi_burst_ctrl;
    localparam int W = 9;
    localparam int D = 8;
    localparam int G = 4;
    localparam int T = 256;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_dat = '0;
    logic         go = 1'b0;
    logic         rx_rd = 1'b0;
    logic         LOAD = 1'b1;
    logic [W-1:0] DO = '0;
    logic         tx_full, st, rx_empty, busy, ovf, err;
    logic [W-1:0] DI, rx_dat, last_rx;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model state
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];
    logic [W-1:0] sent_q[$];
    logic [W-1:0] st_log[$];
    logic         ovf_m = 1'b0;
    logic         err_m = 1'b0;
    logic [W-1:0] last_m = '0;

    // master / monitor control
    bit alive = 1'b1;
    bit long_frame = 1'b0;
    bit hold_chk = 1'b1;
    bit gap_chk = 1'b0;
    bit go_pend = 1'b0;
    int rise_cyc = 0;
    int go_cyc = 0;
    int st_cyc = 0;
    int idle_cyc = 0;

    spi_burst_ctrl #(.WIDTH(W), .DEPTH(D), .GAP(G), .TMO(T)) dut (
        .clk      (clk),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_dat   (wr_dat),
        .go       (go),
        .tx_full  (tx_full),
        .st       (st),
        .DI       (DI),
        .LOAD     (LOAD),
        .DO       (DO),
        .rx_rd    (rx_rd),
        .rx_dat   (rx_dat),
        .rx_empty (rx_empty),
        .last_rx  (last_rx),
        .busy     (busy),
        .ovf      (ovf),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // st monitor: logs presented words, checks go->st and LOAD-rise->st spacing
    always @(negedge clk) begin
        if (st === 1'b1) begin
            st_log.push_back(DI);
            if (go_pend) begin
                check("go_lat", cyc - go_cyc, 1);
                go_pend = 1'b0;
            end else if (gap_chk) begin
                check("gap", cyc - rise_cyc, G + 5);
            end
            st_cyc = cyc;
        end
    end

    // behavioural SPI master looping back the inverted word
    initial begin
        forever begin
            @(negedge clk);
            if (st === 1'b1 && alive) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 LOAD = 1'b0;
                repeat (long_frame ? 30 : $urandom_range(4, 16)) @(posedge clk);
                #1;
                if (hold_chk && st_log.size() > 0) check("di_hold", DI, st_log[st_log.size()-1]);
                DO = ~DI;
                LOAD = 1'b1;
                rise_cyc = cyc;
                gap_chk = 1'b1;
            end
        end
    end

    function automatic void model_push(input logic [W-1:0] w);
        if (tx_q.size() < D) tx_q.push_back(w);
        else ovf_m = 1'b1;
    endfunction

    function automatic void model_burst();
        logic [W-1:0] w;
        while (tx_q.size() > 0) begin
            w = tx_q.pop_front();
            sent_q.push_back(w);
            if (rx_q.size() < D) rx_q.push_back(~w);
            else ovf_m = 1'b1;
            last_m = ~w;
        end
    endfunction

    function automatic void model_timeout();
        sent_q.push_back(tx_q.pop_front());
        err_m = 1'b1;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        clr = 1'b1; wr_en = 1'b0; go = 1'b0; rx_rd = 1'b0;
        #1;
        check("rst_st", st, 0);
        check("rst_di", DI, 0);
        check("rst_txfull", tx_full, 0);
        check("rst_rxempty", rx_empty, 1);
        check("rst_rxdat", rx_dat, 0);
        check("rst_lastrx", last_rx, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);
        tx_q.delete(); rx_q.delete(); sent_q.delete(); st_log.delete();
        ovf_m = 1'b0; err_m = 1'b0; last_m = '0; go_pend = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] w);
        @(negedge clk);
        wr_en = 1'b1; wr_dat = w;
        model_push(w);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_go(input bit starts);
        @(negedge clk);
        go = 1'b1;
        if (starts) begin
            go_cyc = cyc + 1;
            go_pend = 1'b1;
            gap_chk = 1'b0;
        end
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        idle_cyc = cyc;
        check("idle", busy, 0);
    endtask

    task automatic check_sent();
        int n;
        check("st_cnt", st_log.size(), sent_q.size());
        n = (st_log.size() < sent_q.size()) ? st_log.size() : sent_q.size();
        for (int i = 0; i < n; i++) check("st_di", st_log[i], sent_q[i]);
        check("ovf", ovf, ovf_m);
        check("err", err, err_m);
        check("last_rx", last_rx, last_m);
        st_log.delete(); sent_q.delete();
    endtask

    task automatic drain();
        while (rx_q.size() > 0) begin
            check("rx_nonempty", rx_empty, 0);
            check("rx_dat", rx_dat, rx_q.pop_front());
            @(negedge clk); rx_rd = 1'b1;
            @(negedge clk); rx_rd = 1'b0;
        end
        check("rx_drained", rx_empty, 1);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) push(W'($urandom));
        pulse_go(1'b1);
        model_burst();
        wait_idle(4000);
        check_sent();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: directed two-word burst
        reset_dut();
        push(9'h1A5);
        push(9'h0F3);
        pulse_go(1'b1);
        model_burst();
        wait_idle(4000);
        check_sent();
        check("t1_last", last_rx, 9'h10C);
        drain();

        // 2: TX overflow then full burst
        reset_dut();
        for (int i = 0; i < D + 1; i++) begin
            push(W'($urandom));
            if (i == D - 1) begin
                check("t2_full8", tx_full, 1);
                check("t2_ovf8", ovf, 0);
            end
        end
        check("t2_full9", tx_full, 1);
        check("t2_ovf9", ovf, 1);
        pulse_go(1'b1);
        model_burst();
        wait_idle(8000);
        check_sent();
        check("t2_txfull", tx_full, 0);
        drain();

        // 3: dead master -> timeout, retry
        reset_dut();
        alive = 1'b0;
        for (int i = 0; i < 3; i++) push(W'($urandom));
        pulse_go(1'b1);
        model_timeout();
        wait_idle(T + 50);
        check("t3_tmo_len", idle_cyc - st_cyc, T);
        check_sent();
        alive = 1'b1;
        pulse_go(1'b1);
        model_burst();
        wait_idle(4000);
        check_sent();
        drain();

        // 4: RX overflow on ninth capture
        reset_dut();
        send_random(D);
        check("t4_ovf8", ovf, 0);
        send_random(1);
        check("t4_ovf9", ovf, 1);
        drain();

        // 5: clr during WAIT_HI
        reset_dut();
        long_frame = 1'b1;
        hold_chk = 1'b0;
        for (int i = 0; i < D; i++) push(W'($urandom));
        pulse_go(1'b1);
        begin
            int n = 0;
            while (LOAD !== 1'b0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("t5_load_lo", LOAD, 0);
        repeat (4) @(posedge clk);
        push(W'($urandom));
        check("t5_full", tx_full, 1);
        #2 clr = 1'b1;
        #1;
        check("t5_st", st, 0);
        check("t5_busy", busy, 0);
        check("t5_rxempty", rx_empty, 1);
        check("t5_txfull", tx_full, 0);
        @(negedge clk);
        clr = 1'b0;
        st_log.delete(); tx_q.delete();
        repeat (50) @(negedge clk);
        check("t5_nocapt", rx_empty, 1);
        check("t5_lastrx", last_rx, 0);
        check("t5_idle", busy, 0);
        check("t5_nost", st_log.size(), 0);
        long_frame = 1'b0;
        hold_chk = 1'b1;

        // 6: go while busy, rx_rd on empty
        reset_dut();
        for (int i = 0; i < 3; i++) push(W'($urandom));
        pulse_go(1'b1);
        model_burst();
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(negedge clk);
            pulse_go(1'b0);
        end
        wait_idle(4000);
        check_sent();
        drain();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rx_rd = 1'b1;
            @(negedge clk); rx_rd = 1'b0;
        end
        check("t6_empty", rx_empty, 1);
        check("t6_rxdat", rx_dat, 0);
        pulse_go(1'b0);
        repeat (3) @(negedge clk);
        check("t6_go_empty", busy, 0);
        send_random(1);
        drain();

        // 7: random bursts
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            send_random($urandom_range(1, D));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
